lift_call_scheduler: RTL and testbench

LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

---
 rtl/lift_call_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_lift_call_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lift_call_scheduler
// Description : Debounced call-button capture and next-target selection for a
//               single lift car, handing targets to a motion stage.
// Revision    : 1.0  initial release
// ============================================================================
module lift_call_scheduler #(
    parameter int NFLOORS      = 9,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [NFLOORS-1:0] SW,
    input  logic               KEY0,
    input  logic [3:0]         CUR_FLOOR,
    input  logic               ARRIVED,
    input  logic               TGT_ACK,
    output logic [3:0]         TGT_FLOOR,
    output logic               TGT_VALID,
    output logic [NFLOORS-1:0] PENDING,
    output logic [1:0]         DIR,
    output logic               REQ_ERR
);

    localparam int               c_cnt_w     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]       c_top_floor = 4'(NFLOORS - 1);
    localparam logic [1:0]       c_dir_idle  = 2'd0;
    localparam logic [1:0]       c_dir_up    = 2'd1;
    localparam logic [1:0]       c_dir_down  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_OFFER  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_key_meta;
    logic                 r_key_sync;
    logic                 r_key_db;
    logic [c_cnt_w-1:0]   r_db_cnt;
    logic                 w_db_done;
    logic                 w_press;
    logic                 w_sw_onehot;
    logic                 w_arrive;
    logic [NFLOORS-1:0]   w_pend_next;
    logic [3:0]           w_cur;
    logic [3:0]           w_above;
    logic [3:0]           w_below;
    logic                 w_above_found;
    logic                 w_below_found;
    logic [3:0]           w_pick;
    logic [3:0]           w_tgt_next;
    logic [1:0]           w_dir_next;

    // Synchronizer resets to the released level so reset never fakes a press.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
        end else begin
            r_key_meta <= KEY0;
            r_key_sync <= r_key_meta;
        end
    end

    assign w_db_done = (r_key_sync != r_key_db) && (r_db_cnt == c_db_last);
    assign w_press   = w_db_done && !r_key_sync;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_key_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_key_sync == r_key_db) begin
            r_db_cnt <= '0;
        end else if (w_db_done) begin
            r_key_db <= r_key_sync;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_sw_onehot = $onehot(SW);
    assign w_arrive    = (r_state == S_WAIT) && ARRIVED;

    // Set before clear so an arrival beats a same-cycle call for that floor.
    always_comb begin
        w_pend_next = PENDING;
        if (w_press && w_sw_onehot) begin
            w_pend_next = w_pend_next | SW;
        end
        if (w_arrive) begin
            w_pend_next[TGT_FLOOR] = 1'b0;
        end
    end

    assign w_cur = (CUR_FLOOR > c_top_floor) ? c_top_floor : CUR_FLOOR;

    always_comb begin
        w_above_found = 1'b0;
        w_above       = '0;
        w_below_found = 1'b0;
        w_below       = '0;
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (PENDING[i] && (4'(i) > w_cur)) begin
                w_above_found = 1'b1;
                w_above       = 4'(i);
            end
        end
        for (int i = 0; i < NFLOORS; i++) begin
            if (PENDING[i] && (4'(i) < w_cur)) begin
                w_below_found = 1'b1;
                w_below       = 4'(i);
            end
        end
    end

    always_comb begin
        w_pick = w_cur;
        if (!PENDING[w_cur]) begin
            case (DIR)
                c_dir_up:   w_pick = w_above_found ? w_above : w_below;
                c_dir_down: w_pick = w_below_found ? w_below : w_above;
                default: begin
                    if (w_above_found && w_below_found) begin
                        w_pick = ((w_cur - w_below) <= (w_above - w_cur)) ? w_below : w_above;
                    end else if (w_above_found) begin
                        w_pick = w_above;
                    end else begin
                        w_pick = w_below;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tgt_next   = TGT_FLOOR;
        w_dir_next   = DIR;
        unique case (r_state)
            S_IDLE: begin
                if (PENDING != '0) begin
                    w_state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                w_tgt_next = w_pick;
                if (w_pick > w_cur) begin
                    w_dir_next = c_dir_up;
                end else if (w_pick < w_cur) begin
                    w_dir_next = c_dir_down;
                end
                w_state_next = S_OFFER;
            end
            S_OFFER: begin
                if (TGT_ACK) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ARRIVED) begin
                    w_state_next = S_IDLE;
                    if (w_pend_next == '0) begin
                        w_dir_next = c_dir_idle;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            PENDING   <= '0;
            TGT_FLOOR <= '0;
            DIR       <= c_dir_idle;
            REQ_ERR   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            PENDING   <= w_pend_next;
            TGT_FLOOR <= w_tgt_next;
            DIR       <= w_dir_next;
            REQ_ERR   <= w_press && !w_sw_onehot;
        end
    end

    assign TGT_VALID = (r_state == S_OFFER);

endmodule
`default_nettype wire

// File: tb/tb_lift_call_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lift_call_scheduler
// Description : Scoreboard bench for lift_call_scheduler target offers.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] sw;
    logic       key0;
    logic [3:0] cur_floor;
    logic       arrived;
    logic       tgt_ack;
    logic [3:0] tgt_floor;
    logic       tgt_valid;
    logic [8:0] pending;
    logic [1:0] dir;
    logic       req_err;

    always #5 clk = ~clk;

    lift_call_scheduler #(
        .NFLOORS      (9),
        .DEBOUNCE_CYC (4)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .SW        (sw),
        .KEY0      (key0),
        .CUR_FLOOR (cur_floor),
        .ARRIVED   (arrived),
        .TGT_ACK   (tgt_ack),
        .TGT_FLOOR (tgt_floor),
        .TGT_VALID (tgt_valid),
        .PENDING   (pending),
        .DIR       (dir),
        .REQ_ERR   (req_err)
    );

    typedef struct packed {
        logic [3:0] floor;
        logic [1:0] dir;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   err_pulses = 0;

    always @(negedge clk) begin
        if (req_err) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_offer(input logic [3:0] f, input logic [1:0] d);
        exp_t e;
        e.floor = f;
        e.dir   = d;
        sb.push_back(e);
    endtask

    task automatic press(input logic [8:0] s);
        sw   = s;
        key0 = 1'b0;
        repeat (8) @(negedge clk);
        key0 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic arrive(input logic [3:0] f);
        cur_floor = f;
        arrived   = 1'b1;
        @(negedge clk);
        arrived   = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve(input int hold);
        int   t;
        exp_t e;
        t = 0;
        while (!tgt_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!tgt_valid) begin
            chk("offer_timeout", tgt_valid, 1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("tgt_floor", tgt_floor, e.floor);
        chk("tgt_dir", dir, e.dir);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("valid_hold", tgt_valid, 1);
            chk("floor_hold", tgt_floor, e.floor);
        end
        tgt_ack = 1'b1;
        @(negedge clk);
        tgt_ack = 1'b0;
        chk("valid_drop", tgt_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t;
        logic [8:0] s;
        rst       = 1'b1;
        key0      = 1'b1;
        sw        = '0;
        cur_floor = '0;
        arrived   = 1'b0;
        tgt_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pending", pending, 0);
        chk("rst_valid", tgt_valid, 0);
        chk("rst_floor", tgt_floor, 0);
        chk("rst_dir", dir, 0);
        chk("rst_err", req_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Short glitch must not register a call.
        key0 = 1'b0;
        repeat (2) @(negedge clk);
        key0 = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_pending", pending, 0);
        chk("glitch_err", err_pulses, 0);
        chk("glitch_valid", tgt_valid, 0);

        // Single call from floor 0 to floor 5, with latency from the press event.
        cur_floor = 4'd0;
        sw        = 9'h020;
        expect_offer(4'd5, 2'd1);
        key0 = 1'b0;
        t = 0;
        while (pending == 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("press_pending", pending, 9'h020);
        chk("lat_pend_cycle", tgt_valid, 0);
        @(negedge clk);
        chk("lat_select_cycle", tgt_valid, 0);
        @(negedge clk);
        chk("lat_offer_cycle", tgt_valid, 1);
        key0 = 1'b1;
        serve(0);
        arrive(4'd5);
        chk("s1_pending", pending, 0);
        chk("s1_dir", dir, 0);
        repeat (8) @(negedge clk);

        // Invalid selections raise a single-cycle error and record nothing.
        press(9'h006);
        chk("multi_err", err_pulses, 1);
        chk("multi_pending", pending, 0);
        press(9'h000);
        chk("zero_err", err_pulses, 2);
        chk("zero_pending", pending, 0);

        // Collective up then down sweep.
        cur_floor = 4'd0;
        expect_offer(4'd3, 2'd1);
        press(9'h008);
        serve(0);
        press(9'h040);
        press(9'h002);
        chk("sweep_pending", pending, 9'h04A);
        expect_offer(4'd6, 2'd1);
        arrive(4'd3);
        chk("sweep_dir_keep", dir, 1);
        chk("sweep_pending2", pending, 9'h042);
        serve(0);
        expect_offer(4'd1, 2'd2);
        arrive(4'd6);
        serve(0);
        arrive(4'd1);
        chk("sweep_dir_idle", dir, 0);
        chk("sweep_pending_end", pending, 0);

        // Held offer, new call during offer, stray arrival ignored.
        cur_floor = 4'd1;
        expect_offer(4'd7, 2'd1);
        press(9'h080);
        press(9'h004);
        arrived = 1'b1;
        @(negedge clk);
        arrived = 1'b0;
        @(negedge clk);
        chk("hold_pending", pending, 9'h084);
        chk("hold_valid", tgt_valid, 1);
        chk("hold_floor", tgt_floor, 7);
        serve(10);
        expect_offer(4'd2, 2'd2);
        arrive(4'd7);
        serve(0);
        arrive(4'd2);
        chk("hold_dir_idle", dir, 0);

        // Out-of-range current floor reads as the top floor.
        cur_floor = 4'd15;
        expect_offer(4'd8, 2'd0);
        press(9'h100);
        serve(0);
        arrive(4'd8);
        chk("clamp_pending", pending, 0);
        chk("clamp_dir", dir, 0);

        // Reset while waiting with every floor called.
        cur_floor = 4'd0;
        expect_offer(4'd8, 2'd1);
        press(9'h100);
        serve(0);
        for (int i = 0; i < 8; i++) begin
            s = 9'h001 << i;
            press(s);
        end
        chk("full_pending", pending, 9'h1FF);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_valid", tgt_valid, 0);
        chk("mid_rst_floor", tgt_floor, 0);
        chk("mid_rst_dir", dir, 0);
        chk("mid_rst_err", req_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        arrived = 1'b1;
        @(negedge clk);
        arrived = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_pending", pending, 0);
        chk("post_rst_valid", tgt_valid, 0);
        chk("post_rst_dir", dir, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
